// File: rtl/neuron_mac_driver.sv
// neuron_mac_driver: per-neuron fetch/multiply/accumulate sequencer with valid/ready result port.
// Optional bias slot per neuron when NEURON_BIAS_EN is defined.
module neuron_mac_driver #(
  parameter int N           = 10,
  parameter int Q           = 9,
  parameter int NUM_IN      = 4,
  parameter int NUM_NEURONS = 4,
  parameter int AW          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        x_addr,
  input  logic signed [N-1:0]  x_data,
  output logic [AW-1:0]        w_addr,
  input  logic signed [N-1:0]  w_data,
  output logic                 acc_rst,
  output logic                 acc_add,
  output logic signed [N-1:0]  acc_a,
  input  logic signed [N-1:0]  acc_out,
  output logic signed [N-1:0]  res_data,
  output logic [AW-1:0]        res_idx,
  output logic                 res_valid,
  input  logic                 res_ready
);
`ifdef NEURON_BIAS_EN
  localparam int K = NUM_IN + 1;
`else
  localparam int K = NUM_IN;
`endif
  localparam logic [AW-1:0] I_LAST = AW'(K - 1);
  localparam logic [AW-1:0] N_LAST = AW'(NUM_NEURONS - 1);
  localparam logic signed [2*N-1:0] P_MAX = (2*N)'(2**(N-1) - 1);
  localparam logic signed [2*N-1:0] P_MIN = -P_MAX - 1;
  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, OUT} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_i, r_n;
  logic [1:0] r_d;
  logic r_v1, r_b1, r_add, r_done;
  logic signed [N-1:0] r_acc_a, r_res;
  logic signed [2*N-1:0] w_prod, w_sh;
  logic signed [N-1:0] w_sat;
  logic w_bias;
`ifdef NEURON_BIAS_EN
  assign w_bias = r_i == AW'(NUM_IN);
`else
  assign w_bias = 1'b0;
`endif
  assign w_prod = x_data * w_data;
  assign w_sh   = w_prod >>> Q;
  assign w_sat  = w_sh > P_MAX ? P_MAX[N-1:0] : w_sh < P_MIN ? P_MIN[N-1:0] : w_sh[N-1:0];
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CLR : IDLE;
      CLR:     w_next = RUN;
      RUN:     w_next = r_i == I_LAST ? DRAIN : RUN;
      DRAIN:   w_next = r_d == 2'd2 ? OUT : DRAIN;
      OUT:     w_next = res_ready ? (r_n == N_LAST ? IDLE : CLR) : OUT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy      = r_state != IDLE;
    res_valid = r_state == OUT;
    acc_rst   = rst || r_state == CLR;
  end
  // Fetch valid and bias flags follow the address by one cycle to line up with memory data.
  always_ff @(posedge clk)
    if (rst) begin
      r_i     <= '0;
      r_n     <= '0;
      r_d     <= '0;
      r_v1    <= 1'b0;
      r_b1    <= 1'b0;
      r_add   <= 1'b0;
      r_done  <= 1'b0;
      r_acc_a <= '0;
      r_res   <= '0;
    end else begin
      r_i     <= (r_state == RUN && r_i != I_LAST) ? r_i + 1'b1 : '0;
      r_d     <= r_state == DRAIN ? r_d + 1'b1 : '0;
      r_v1    <= r_state == RUN;
      r_b1    <= r_state == RUN && w_bias;
      r_add   <= r_v1;
      r_acc_a <= r_v1 ? (r_b1 ? w_data : w_sat) : '0;
      r_done  <= r_state == OUT && res_ready && r_n == N_LAST;
      if (r_state == DRAIN && r_d == 2'd2) r_res <= acc_out;
      if (r_state == OUT && res_ready) r_n <= r_n == N_LAST ? '0 : r_n + 1'b1;
    end
  assign x_addr   = r_i;
  assign w_addr   = w_bias ? AW'(NUM_IN * NUM_NEURONS) + r_n : AW'(r_n * NUM_IN) + r_i;
  assign acc_add  = r_add;
  assign acc_a    = r_acc_a;
  assign done     = r_done;
  assign res_data = r_res;
  assign res_idx  = r_n;
endmodule

// File: tb/tb_neuron_mac_driver.sv
// tb_neuron_mac_driver: drives layers through neuron_mac_driver with memory and accumulator models.
module tb_neuron_mac_driver;
  localparam int N = 10, Q = 9, NI = 4, NN = 4, AW = 8;
`ifdef NEURON_BIAS_EN
  localparam int K = NI + 1;
  localparam bit BIAS = 1'b1;
`else
  localparam int K = NI;
  localparam bit BIAS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic busy, done, acc_rst, acc_add, res_valid;
  logic [AW-1:0] x_addr, w_addr, res_idx;
  logic signed [N-1:0] x_data, w_data, acc_a, acc_out, res_data, acc;
  logic signed [N-1:0] xm [256];
  logic signed [N-1:0] wm [256];
  int checks = 0, failures = 0, n_add = 0;
  int q_prod[$];
  int q_res[$];

  neuron_mac_driver #(.N(N), .Q(Q), .NUM_IN(NI), .NUM_NEURONS(NN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
    .acc_rst(acc_rst), .acc_add(acc_add), .acc_a(acc_a), .acc_out(acc_out),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    x_data <= xm[x_addr];
    w_data <= wm[w_addr];
    acc    <= acc_rst ? '0 : acc_add ? acc + acc_a : acc;
  end
  assign acc_out = acc;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_prod(input int x, input int w);
    int s, lim;
    lim = 2 ** (N - 1);
    s = (x * w) >>> Q;
    return s > lim - 1 ? lim - 1 : s < -lim ? -lim : s;
  endfunction

  // Expected products in stream order and wrapped N-bit sums per neuron.
  task automatic load_expect();
    logic signed [N-1:0] t;
    int sum, p;
    q_prod.delete();
    q_res.delete();
    for (int n = 0; n < NN; n++) begin
      sum = 0;
      for (int i = 0; i < NI; i++) begin
        p = sat_prod(xm[i], wm[n*NI+i]);
        q_prod.push_back(p);
        sum += p;
      end
      if (BIAS) begin
        p = wm[NI*NN+n];
        q_prod.push_back(p);
        sum += p;
      end
      t = sum[N-1:0];
      q_res.push_back(int'(t));
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 256; i++) begin
      xm[i] = N'($urandom);
      wm[i] = N'($urandom);
    end
  endtask

  task automatic check_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acc_add", acc_add, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_acc_a", acc_a, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_idx", res_idx, 0);
    chk("rst_x_addr", x_addr, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_acc_rst", acc_rst, 1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!res_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid_timeout", res_valid, 1);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (acc_add) begin
        n_add++;
        if (q_prod.size() == 0) chk("spurious_add", acc_add, 0);
        else chk("acc_a", acc_a, q_prod.pop_front());
      end else chk("acc_a_idle", acc_a, 0);
      if (res_valid) chk("add_in_out", acc_add, 0);
    end

  task automatic run_layer(input int stall, input int abort_at);
    bit aborted = 1'b0;
    load_expect();
    n_add = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < NN; n++) begin
      wait_valid();
      chk("res_idx", res_idx, n);
      chk("res_data", res_data, q_res[n]);
      chk("add_count", n_add, K);
      if (stall > 0 && n == 1) begin
        for (int k = 0; k < stall; k++) begin
          start = (k == 2);
          @(negedge clk);
          chk("hold_valid", res_valid, 1);
          chk("hold_data", res_data, q_res[n]);
          chk("hold_idx", res_idx, n);
        end
        start = 1'b0;
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_add = 0;
      chk("done_pulse", done, n == NN - 1);
      chk("busy_between", busy, n != NN - 1);
      chk("valid_drop", res_valid, 0);
      if (n == abort_at - 1) begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        q_prod.delete();
        aborted = 1'b1;
        break;
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end
    if (!aborted) chk("no_leftover_products", q_prod.size(), 0);
  endtask

  initial begin
    randomize_mem();
    xm[0] = 10'sd256;  xm[1] = 10'sd256;  xm[2] = -10'sd512; xm[3] = -10'sd512;
    wm[0] = 10'sd256;  wm[1] = 10'sd256;  wm[2] = -10'sd512; wm[3] = 10'sd256;
    wm[NI*NN] = 10'sd100;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    run_layer(0, -1);
    randomize_mem();
    run_layer(5, -1);
    randomize_mem();
    run_layer(0, 2);
    run_layer(0, -1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_with_rst_ignored", busy, 0);
    randomize_mem();
    run_layer(3, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
